uart_echo_engine: RTL and testbench
===================================

Name: uart_echo_engine

Overview:
Parametrised echo/transform engine between the osdvu uart core's receive and transmit sides.
- Received bytes are case-transformed at write time and buffered in a FIFO.
- Bytes are replayed through a transmit handshake state machine, with optional CR->CRLF expansion.
- Unlike the single-register echo, no byte is lost while the transmitter is busy, and every accepted byte produces exactly one transmit pulse.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
ADDR_W, 4, log2(DEPTH)
DROP_ERRORS, 1, 1 = discard bytes flagged by recv_error; 0 = buffer them anyway
CRLF_EXPAND, 1, 1 = after echoing 8'h0D, also transmit 8'h0A

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous, active-low reset
received  input  1  single-cycle strobe from uart core, rx_byte valid
rx_byte  input  8  received byte
recv_error  input  1  uart core receive error, sampled with received
is_transmitting  input  1  uart core transmitter busy
mode  input  2  0 pass, 1 to-upper, 2 to-lower, 3 swap case
clr_overflow  input  1  clears overflow flag
transmit  output  1  single-cycle transmit request to uart core
tx_byte  output  8  byte to transmit, held stable from pulse until next load
fifo_count  output  ADDR_W+1  current occupancy 0..DEPTH
overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (RST_N low, any time, including mid-frame): transmit=0, tx_byte=8'h00, fifo_count=0, pointers=0, overflow=0, lf_pending=0, state=IDLE. Effect is immediate, not clock-dependent.
- Transform is combinational on rx_byte, applied before the FIFO write:
  - letters: 8'h61..8'h7A are lower case, 8'h41..8'h5A are upper case.
  - to-upper clears bit 5 of lower-case letters only.
  - to-lower sets bit 5 of upper-case letters only.
  - swap toggles bit 5 of any letter.
  - non-letters are always passed unchanged.
  - mode is sampled in the push cycle.
- Push condition: received=1 and not (DROP_ERRORS and recv_error).
  - Push with count<DEPTH, or with a pop in the same cycle: write at wr_ptr, wr_ptr+1 mod DEPTH.
  - Push with count=DEPTH and no pop: byte dropped, overflow<=1, count unchanged.
- Pop occurs only in IDLE with count>0: head loaded to tx_byte, rd_ptr+1 mod DEPTH.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap naturally at DEPTH.
- overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Otherwise clr_overflow=1 clears it.
- FSM states: IDLE, REQ, WAIT_BUSY, WAIT_DONE.
  - IDLE: if count>0, pop, transmit<=1, go to REQ. If the popped byte (post-transform) is 8'h0D and CRLF_EXPAND, set lf_pending<=1.
  - REQ: transmit is high for exactly this cycle. transmit<=0, go to WAIT_BUSY.
  - WAIT_BUSY: stay until is_transmitting=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until is_transmitting=0.
    - If lf_pending: tx_byte<=8'h0A, lf_pending<=0, transmit<=1, go to REQ.
    - Else go to IDLE.
- Latency: received high in cycle N with FIFO empty and FSM idle -> fifo_count=1 in N+1 -> transmit high in N+2 with tx_byte valid.
- The FSM never pulses transmit while is_transmitting=1.
- The LF is inserted before any further FIFO byte and does not occupy a FIFO slot.
- tx_byte holds its last value when idle.
- fifo_count is registered and reflects pushes and pops completed at the previous edge.

Test Plan:
- Reset values, mode=1: rx 8'h61 ('a') -> transmit pulse in N+2 with tx_byte=8'h41; a second 8'h31 is echoed as 8'h31; exactly one pulse per byte.
- Mode sweep: rx 8'h5A with mode=2 -> 8'h7A; with mode=3 -> 8'h7A; rx 8'h7B with mode=1 -> 8'h7B unchanged; rx 8'h40 with mode=3 -> 8'h40 unchanged.
- Burst, DEPTH=16: 20 back-to-back bytes while is_transmitting is held high -> fifo_count saturates at 16, overflow=1, 16 bytes echoed in order; assert clr_overflow -> overflow=0.
- CRLF: CRLF_EXPAND=1, rx 8'h0D then 8'h41 -> transmit sequence 8'h0D, 8'h0A, 8'h41; with CRLF_EXPAND=0 -> 8'h0D, 8'h41.
- Error handling: rx 8'h55 with recv_error=1 -> DROP_ERRORS=1 gives no push, no pulse; DROP_ERRORS=0 gives 8'h55 echoed.
- Reset mid-operation: RST_N low during WAIT_DONE with 3 bytes queued and lf_pending=1 -> immediately transmit=0, fifo_count=0, overflow=0; no further pulses after release until a new byte arrives.

Source files
------------

// File: rtl/uart_echo_engine.sv
// Echo/transform engine between a UART core's receive and transmit sides.
// Received bytes are case-transformed, queued in a FIFO and replayed one per transmit handshake.
module uart_echo_engine #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter bit          DROP_ERRORS = 1'b1,
  parameter bit          CRLF_EXPAND = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              received,
  input  logic [7:0]        rx_byte,
  input  logic              recv_error,
  input  logic              is_transmitting,
  input  logic [1:0]        mode,
  input  logic              clr_overflow,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitBusy, StWaitDone} state_e;

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

  function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
    logic       is_lo;
    logic       is_up;
    logic [7:0] r;
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    r     = b;
    case (m)
      2'd1:    if (is_lo) r[5] = 1'b0;
      2'd2:    if (is_up) r[5] = 1'b1;
      2'd3:    if (is_lo || is_up) r[5] = ~b[5];
      default: r = b;
    endcase
    return r;
  endfunction

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  state_e            state_q, state_d;
  logic              transmit_q, transmit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              lf_pending_q, lf_pending_d;

  logic       push, pop, full, wr_en, ovf_set;
  logic [7:0] wr_data, head;

  always_comb begin
    push    = received && !(DROP_ERRORS && recv_error);
    full    = (count_q == FullCnt);
    // Popping is held off while the core is busy so a pulse never lands mid-frame.
    pop     = (state_q == StIdle) && (count_q != '0) && !is_transmitting;
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
    wr_data = xform(rx_byte, mode);
    head    = mem_q[rd_ptr_q];

    wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    transmit_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    lf_pending_d = lf_pending_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          tx_byte_d  = head;
          transmit_d = 1'b1;
          state_d    = StReq;
          if (CRLF_EXPAND && (head == 8'h0D)) lf_pending_d = 1'b1;
        end
      end
      StReq: state_d = StWaitBusy;
      StWaitBusy: begin
        if (is_transmitting) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!is_transmitting) begin
          // The LF goes out ahead of any queued byte and never occupies a FIFO slot.
          if (lf_pending_q) begin
            tx_byte_d    = 8'h0A;
            lf_pending_d = 1'b0;
            transmit_d   = 1'b1;
            state_d      = StReq;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      state_q      <= StIdle;
      transmit_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      lf_pending_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      transmit_q   <= transmit_d;
      tx_byte_q    <= tx_byte_d;
      lf_pending_q <= lf_pending_d;
    end
  end

  assign transmit   = transmit_q;
  assign tx_byte    = tx_byte_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine: a default instance and one with DROP_ERRORS=0,
// CRLF_EXPAND=0 share inputs; each has its own simple model of a busy UART transmitter.
module tb_uart_echo_engine;

  logic       CLK;
  logic       RST_N;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic [1:0] mode;
  logic       clr_overflow;
  logic       hold;

  logic       tx_a, tx_b;
  logic [7:0] txb_a, txb_b;
  logic [4:0] cnt_a, cnt_b;
  logic       ovf_a, ovf_b;
  logic       is_tx_a, is_tx_b;

  int busy_a, busy_b, viol_a, viol_b;
  int n_checks, n_pass;
  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];

  assign is_tx_a = hold || (busy_a != 0);
  assign is_tx_b = hold || (busy_b != 0);

  uart_echo_engine dut (
    .CLK(CLK), .RST_N(RST_N), .received(received), .rx_byte(rx_byte),
    .recv_error(recv_error), .is_transmitting(is_tx_a), .mode(mode),
    .clr_overflow(clr_overflow), .transmit(tx_a), .tx_byte(txb_a),
    .fifo_count(cnt_a), .overflow(ovf_a)
  );

  uart_echo_engine #(.DROP_ERRORS(1'b0), .CRLF_EXPAND(1'b0)) dut_alt (
    .CLK(CLK), .RST_N(RST_N), .received(received), .rx_byte(rx_byte),
    .recv_error(recv_error), .is_transmitting(is_tx_b), .mode(mode),
    .clr_overflow(clr_overflow), .transmit(tx_b), .tx_byte(txb_b),
    .fifo_count(cnt_b), .overflow(ovf_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Transmitter model: each pulse is captured and makes the line busy for a few cycles.
  always @(negedge CLK) begin
    if (tx_a && is_tx_a) viol_a++;
    if (tx_b && is_tx_b) viol_b++;
    if (busy_a > 0) busy_a--;
    if (busy_b > 0) busy_b--;
    if (tx_a) begin cap_a.push_back(txb_a); busy_a = 4; end
    if (tx_b) begin cap_b.push_back(txb_b); busy_b = 4; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [7:0] at_a(input int i);
    return (i < cap_a.size()) ? cap_a[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] at_b(input int i);
    return (i < cap_b.size()) ? cap_b[i] : 8'hxx;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    received   = 1'b1;
    rx_byte    = b;
    recv_error = e;
    tick();
    received   = 1'b0;
    recv_error = 1'b0;
  endtask

  task automatic clear_caps();
    cap_a.delete();
    cap_b.delete();
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #1;
    n_checks++; if (tx_a !== 1'b0) $display("FAIL reset_transmit got %b want 0", tx_a); else n_pass++;
    n_checks++; if (txb_a !== 8'h00) $display("FAIL reset_tx_byte got %h want 00", txb_a);
    else n_pass++;
    n_checks++; if (cnt_a !== 5'd0) $display("FAIL reset_count got %0d want 0", cnt_a); else n_pass++;
    n_checks++; if (ovf_a !== 1'b0) $display("FAIL reset_overflow got %b want 0", ovf_a); else n_pass++;
    wait_cycles(3);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_latency_upper();
    mode = 2'd1;
    clear_caps();
    send(8'h61, 1'b0);
    n_checks++; if (cnt_a !== 5'd1) $display("FAIL lat_count got %0d want 1", cnt_a); else n_pass++;
    n_checks++; if (tx_a !== 1'b0) $display("FAIL lat_early got %b want 0", tx_a); else n_pass++;
    tick();
    n_checks++; if (tx_a !== 1'b1) $display("FAIL lat_pulse got %b want 1", tx_a); else n_pass++;
    n_checks++; if (txb_a !== 8'h41) $display("FAIL lat_byte got %h want 41", txb_a); else n_pass++;
    wait_cycles(20);
    send(8'h31, 1'b0);
    wait_cycles(20);
    n_checks++; if (cap_a.size() !== 2) $display("FAIL upper_pulses got %0d want 2", cap_a.size());
    else n_pass++;
    n_checks++; if (at_a(1) !== 8'h31) $display("FAIL upper_digit got %h want 31", at_a(1));
    else n_pass++;
  endtask

  task automatic test_modes();
    logic [7:0] vin  [6] = '{8'h5A, 8'h5A, 8'h7B, 8'h40, 8'h61, 8'h41};
    logic [1:0] vmd  [6] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd3};
    logic [7:0] vexp [6] = '{8'h7A, 8'h7A, 8'h7B, 8'h40, 8'h61, 8'h61};
    for (int i = 0; i < 6; i++) begin
      clear_caps();
      mode = vmd[i];
      send(vin[i], 1'b0);
      wait_cycles(20);
      n_checks++;
      if (cap_a.size() !== 1) $display("FAIL mode_pulses[%0d] got %0d want 1", i, cap_a.size());
      else n_pass++;
      n_checks++;
      if (at_a(0) !== vexp[i]) $display("FAIL mode_byte[%0d] got %h want %h", i, at_a(0), vexp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_burst();
    mode = 2'd0;
    hold = 1'b1;
    clear_caps();
    for (int i = 0; i < 20; i++) begin
      received = 1'b1;
      rx_byte  = 8'h30 + 8'(i);
      tick();
    end
    received = 1'b0;
    n_checks++; if (cnt_a !== 5'd16) $display("FAIL burst_count got %0d want 16", cnt_a);
    else n_pass++;
    n_checks++; if (ovf_a !== 1'b1) $display("FAIL burst_overflow got %b want 1", ovf_a); else n_pass++;
    wait_cycles(3);
    n_checks++; if (cnt_a !== 5'd16) $display("FAIL burst_held got %0d want 16", cnt_a); else n_pass++;
    hold = 1'b0;
    wait_cycles(200);
    n_checks++; if (cap_a.size() !== 16) $display("FAIL burst_pulses got %0d want 16", cap_a.size());
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (at_a(i) !== 8'h30 + 8'(i))
        $display("FAIL burst_order[%0d] got %h want %h", i, at_a(i), 8'h30 + 8'(i));
      else n_pass++;
    end
    n_checks++; if (ovf_a !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf_a); else n_pass++;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    n_checks++; if (ovf_a !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf_a); else n_pass++;
  endtask

  task automatic test_crlf();
    mode = 2'd0;
    clear_caps();
    send(8'h0D, 1'b0);
    send(8'h41, 1'b0);
    wait_cycles(60);
    n_checks++; if (cap_a.size() !== 3) $display("FAIL crlf_pulses got %0d want 3", cap_a.size());
    else n_pass++;
    n_checks++; if (at_a(0) !== 8'h0D) $display("FAIL crlf_cr got %h want 0D", at_a(0)); else n_pass++;
    n_checks++; if (at_a(1) !== 8'h0A) $display("FAIL crlf_lf got %h want 0A", at_a(1)); else n_pass++;
    n_checks++; if (at_a(2) !== 8'h41) $display("FAIL crlf_next got %h want 41", at_a(2)); else n_pass++;
    n_checks++; if (cap_b.size() !== 2) $display("FAIL nocrlf_pulses got %0d want 2", cap_b.size());
    else n_pass++;
    n_checks++; if (at_b(1) !== 8'h41) $display("FAIL nocrlf_next got %h want 41", at_b(1));
    else n_pass++;
  endtask

  task automatic test_errors();
    clear_caps();
    send(8'h55, 1'b1);
    n_checks++; if (cnt_a !== 5'd0) $display("FAIL err_drop_count got %0d want 0", cnt_a); else n_pass++;
    n_checks++; if (cnt_b !== 5'd1) $display("FAIL err_keep_count got %0d want 1", cnt_b); else n_pass++;
    wait_cycles(20);
    n_checks++; if (cap_a.size() !== 0) $display("FAIL err_drop_pulses got %0d want 0", cap_a.size());
    else n_pass++;
    n_checks++; if (at_b(0) !== 8'h55) $display("FAIL err_keep_byte got %h want 55", at_b(0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mode = 2'd0;
    clear_caps();
    send(8'h0D, 1'b0);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    hold = 1'b1;
    wait_cycles(2);
    n_checks++; if (cnt_a !== 5'd3) $display("FAIL mid_queued got %0d want 3", cnt_a); else n_pass++;
    #3 RST_N = 1'b0;
    #1;
    n_checks++; if (tx_a !== 1'b0) $display("FAIL mid_transmit got %b want 0", tx_a); else n_pass++;
    n_checks++; if (txb_a !== 8'h00) $display("FAIL mid_tx_byte got %h want 00", txb_a); else n_pass++;
    n_checks++; if (cnt_a !== 5'd0) $display("FAIL mid_count got %0d want 0", cnt_a); else n_pass++;
    n_checks++; if (ovf_a !== 1'b0) $display("FAIL mid_overflow got %b want 0", ovf_a); else n_pass++;
    tick();
    RST_N = 1'b1;
    hold  = 1'b0;
    clear_caps();
    wait_cycles(40);
    n_checks++; if (cap_a.size() !== 0) $display("FAIL mid_quiet got %0d want 0", cap_a.size());
    else n_pass++;
    send(8'h61, 1'b0);
    wait_cycles(20);
    n_checks++; if (cap_a.size() !== 1) $display("FAIL mid_resume_n got %0d want 1", cap_a.size());
    else n_pass++;
    n_checks++; if (at_a(0) !== 8'h61) $display("FAIL mid_resume got %h want 61", at_a(0));
    else n_pass++;
  endtask

  task automatic test_busy_guard();
    n_checks++; if (viol_a !== 0) $display("FAIL busy_pulse_a got %0d want 0", viol_a); else n_pass++;
    n_checks++; if (viol_b !== 0) $display("FAIL busy_pulse_b got %0d want 0", viol_b); else n_pass++;
  endtask

  initial begin
    RST_N = 1'b1; received = 1'b0; rx_byte = 8'h00; recv_error = 1'b0;
    mode = 2'd0; clr_overflow = 1'b0; hold = 1'b0;
    busy_a = 0; busy_b = 0; viol_a = 0; viol_b = 0;
    n_checks = 0; n_pass = 0;
    test_reset();
    test_latency_upper();
    test_modes();
    test_burst();
    test_crlf();
    test_errors();
    test_reset_mid();
    test_busy_guard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
